node_duplicator: RTL and testbench
==================================

# node_duplicator

Streaming re-materialisation stage, the inverse of common-subexpression elimination: takes one shared gate node plus its fanout count and emits one private copy per consumer, each with a freshly allocated node ID. It sits after the CSE/strash pass in the netlist pipeline, in front of timing-driven placement, where duplicated drivers are needed to cut shared-net load. Input and output are valid/ready streams of gate tuples.

## Interface
- ID_W, 8, width of node IDs (original and new)
- OP_W, 2, width of gate opcode
- FANOUT_W, 4, width of fanout count (max copies per node = 2^FANOUT_W-1)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  input tuple valid
- in_ready  output  1  block can accept a tuple this cycle
- in_id  input  ID_W  original node ID
- in_op  input  OP_W  gate opcode
- in_a, in_b  input  ID_W  operand node IDs (passed through unchanged)
- in_fanout  input  FANOUT_W  number of copies to emit
- out_valid  output  1  output copy valid
- out_ready  input  1  downstream accepts copy
- out_id  output  ID_W  newly allocated node ID
- out_src_id  output  ID_W  original node ID of this copy
- out_op  output  OP_W  opcode copy
- out_a, out_b  output  ID_W  operand copies
- out_copy  output  FANOUT_W  copy index, 0..fanout-1
- id_overflow  output  1  sticky: ID allocator wrapped

## Operation
- FSM states IDLE, EMIT.
- IDLE: in_ready=1. On in_valid: register id/op/a/b/fanout; fanout=0 → node dropped (dead logic), stay IDLE, nothing emitted; fanout≥1 → copy index=0, go EMIT.
- EMIT: out_valid=1, fields from held registers, out_id=current allocator value. On out_valid&out_ready: allocator increments, copy index increments; if copy index==fanout-1 → last copy.
- in_ready also 1 in EMIT during the cycle the last copy is accepted (back-to-back, no bubble); a tuple accepted then is loaded as in IDLE (fanout=0 → IDLE, else EMIT with index 0).
- Output fields held stable while out_valid&!out_ready.
- Allocator: starts at 0 after reset, +1 per accepted copy only (never for dropped nodes); at 2^ID_W-1 → wraps to 0 and sets id_overflow, which stays 1 until rst.
- Reset values: in_ready=1 (combinational from state IDLE), out_valid=0, out_id=out_src_id=out_a=out_b=0, out_op=0, out_copy=0, id_overflow=0, allocator=0, state IDLE.
- rst mid-EMIT: remaining copies discarded, allocator and id_overflow cleared, next cycle IDLE.

## Timing
- Latency: tuple accepted in cycle N → first copy valid in cycle N+1.
- Throughput: one copy per cycle with out_ready held high; a fanout-k node occupies k cycles; dropped nodes take 1 cycle.
- in_ready depends combinationally on out_ready only in the last-copy case; no combinational path from in_valid to out_valid.
- Simultaneous last-copy accept and new input: allocator continues monotonically; first copy of new node gets previous last ID+1.

## Structure
- Package node_dup_pkg: opcode enum OP_AND=0, OP_OR=1, OP_XOR=2, OP_NOT=3; default ID_W/OP_W/FANOUT_W constants; state enum {IDLE, EMIT}.
- One sub-module: node_id_allocator (counter, increment enable, wrap detect, sticky overflow, sync reset).

## Test plan
- Fanout 3: in_id=5, op=AND, a=1, b=2 after reset, out_ready=1 → cycles N+1..N+3 emit out_id 0,1,2, out_copy 0,1,2, src_id=5, a=1, b=2; out_valid low at N+4.
- Fanout 0 then fanout 1: id=7 fanout 0, then id=8 fanout 1 → no output for 7; one copy for 8 with out_id=0.
- Back-to-back: id=1 fanout 2 followed immediately by id=2 fanout 2, out_ready=1 → four consecutive valid cycles, out_id 0..3, no bubble.
- Backpressure: fanout 2, out_ready low for 3 cycles after first valid → outputs stable at out_id=0, out_copy=0; then copies 0,1 complete; in_ready low throughout.
- Wrap: ID_W=4, feed 17 copies total → 16th copy out_id=15, 17th out_id=0, id_overflow rises after the 16th accepted copy and stays 1.
- Reset mid-operation: fanout 5, assert rst after 2 copies → out_valid=0 next cycle, id_overflow=0; next node's first copy out_id=0.

Source files
------------

// File: rtl/node_dup_pkg.sv
// node_dup_pkg: shared types and default widths for the node duplication stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package node_dup_pkg;

   // Default widths for the duplicator and its ID allocator
   localparam int ID_W_DEF     = 8;
   localparam int OP_W_DEF     = 2;
   localparam int FANOUT_W_DEF = 4;

   // Gate opcodes carried through unchanged on every copy
   typedef enum logic [1:0] {
      OP_AND = 2'd0,
      OP_OR  = 2'd1,
      OP_XOR = 2'd2,
      OP_NOT = 2'd3
   } op_e;

   // Duplicator control states
   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   // True when the copy at index 'copy' is the final one of a node with 'fanout' consumers.
   // Only meaningful for fanout >= 1; a zero-fanout node never enters EMIT.
   function automatic logic is_last_copy(input int unsigned copy, input int unsigned fanout);
      return (copy + 32'd1) == fanout;
   endfunction

endpackage

// File: rtl/node_id_allocator.sv
// node_id_allocator: hands out fresh node IDs in increasing order, one per enabled cycle.
// Latency: new ID visible the cycle after inc; current ID is a plain register output.
// Backpressure: none; the caller pulses inc only when a copy is actually accepted.
module node_id_allocator #(
   parameter int ID_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   output logic [ID_W-1:0] id,
   output logic            overflow
);

   localparam logic [ID_W-1:0] ID_MAX = '1;

   // Counter with wrap to zero; overflow is sticky until reset so downstream can
   // tell that IDs may now collide with ones issued before the wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         id       <= '0;
         overflow <= 1'b0;
      end else if (inc) begin
         if (id == ID_MAX) begin
            id       <= '0;
            overflow <= 1'b1;
         end else begin
            id <= id + ID_W'(1);
         end
      end
   end

endmodule

// File: rtl/node_duplicator.sv
// node_duplicator: re-materialises a shared gate node as one private copy per consumer, each with a fresh ID.
// Latency: tuple accepted in cycle N gives first copy valid in N+1; one copy per cycle with out_ready high.
// Backpressure: copy fields hold while out_ready is low; in_ready rises in EMIT only on the last-copy accept.
module node_duplicator
   import node_dup_pkg::*;
#(
   parameter int ID_W     = ID_W_DEF,
   parameter int OP_W     = OP_W_DEF,
   parameter int FANOUT_W = FANOUT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ID_W-1:0]     in_id,
   input  logic [OP_W-1:0]     in_op,
   input  logic [ID_W-1:0]     in_a,
   input  logic [ID_W-1:0]     in_b,
   input  logic [FANOUT_W-1:0] in_fanout,

   output logic                out_valid,
   input  logic                out_ready,
   output logic [ID_W-1:0]     out_id,
   output logic [ID_W-1:0]     out_src_id,
   output logic [OP_W-1:0]     out_op,
   output logic [ID_W-1:0]     out_a,
   output logic [ID_W-1:0]     out_b,
   output logic [FANOUT_W-1:0] out_copy,

   output logic                id_overflow
);

   state_e              state;
   logic [FANOUT_W-1:0] fanout_q;
   logic [ID_W-1:0]     alloc_id;
   logic                out_fire;
   logic                last_copy;
   logic                in_fire;
   logic                load_new;

   // A copy leaves when presented and taken; the last one frees the input port in the same cycle
   // so a following node starts without a bubble.
   assign out_fire  = out_valid & out_ready;
   assign last_copy = is_last_copy(32'(out_copy), 32'(fanout_q));
   assign in_ready  = (state == IDLE) | (out_fire & last_copy);
   assign in_fire   = in_valid & in_ready;
   // Zero-fanout nodes are dead logic: accepted and dropped without touching the output registers.
   assign load_new  = in_fire & (in_fanout != '0);

   // Control FSM plus the registered copy fields; fields only change on a new load or a copy accept,
   // which keeps them stable under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_src_id <= '0;
         out_op     <= '0;
         out_a      <= '0;
         out_b      <= '0;
         out_copy   <= '0;
         fanout_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_new) begin
                  out_src_id <= in_id;
                  out_op     <= in_op;
                  out_a      <= in_a;
                  out_b      <= in_b;
                  fanout_q   <= in_fanout;
                  out_copy   <= '0;
                  out_valid  <= 1'b1;
                  state      <= EMIT;
               end
            end
            EMIT: begin
               if (out_fire) begin
                  if (!last_copy) begin
                     out_copy <= out_copy + FANOUT_W'(1);
                  end else if (load_new) begin
                     // Back-to-back node: stay in EMIT and restart the copy index.
                     out_src_id <= in_id;
                     out_op     <= in_op;
                     out_a      <= in_a;
                     out_b      <= in_b;
                     fanout_q   <= in_fanout;
                     out_copy   <= '0;
                  end else begin
                     out_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Fresh IDs advance only on accepted copies, so dropped nodes and stalls consume none.
   node_id_allocator #(
      .ID_W (ID_W)
   ) u_alloc (
      .clk      (clk),
      .rst      (rst),
      .inc      (out_fire),
      .id       (alloc_id),
      .overflow (id_overflow)
   );

   assign out_id = alloc_id;

endmodule

// File: tb/tb_node_duplicator.sv
module tb_node_duplicator;
   import node_dup_pkg::*;

   localparam int IDW    = 4;
   localparam int OPW    = 2;
   localparam int FW     = 4;
   localparam int ID_MOD = 1 << IDW;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [IDW-1:0] in_id = '0;
   logic [OPW-1:0] in_op = '0;
   logic [IDW-1:0] in_a = '0;
   logic [IDW-1:0] in_b = '0;
   logic [FW-1:0]  in_fanout = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [IDW-1:0] out_id;
   logic [IDW-1:0] out_src_id;
   logic [OPW-1:0] out_op;
   logic [IDW-1:0] out_a;
   logic [IDW-1:0] out_b;
   logic [FW-1:0]  out_copy;
   logic           id_overflow;

   node_duplicator #(.ID_W(IDW), .OP_W(OPW), .FANOUT_W(FW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_fanout(in_fanout),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_src_id(out_src_id),
      .out_op(out_op), .out_a(out_a), .out_b(out_b), .out_copy(out_copy),
      .id_overflow(id_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int src;
      int op;
      int a;
      int b;
      int copy;
   } exp_t;

   exp_t q[$];
   int   m_next = 0;      // next ID the reference expects to be handed out
   bit   m_ovf = 1'b0;    // reference sticky overflow
   int   errors = 0;
   int   checks = 0;
   int   ready_mode = 0;  // 0: out_ready high, 1: random, 2: held low

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Downstream readiness, updated just after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor / scoreboard: reference model of the stream, sampled on the falling edge
   always @(negedge clk) begin
      exp_t e;
      int   exp_rdy;
      if (rst) begin
         q.delete();
         m_next = 0;
         m_ovf  = 1'b0;
      end else begin
         exp_rdy = (q.size() == 0 || (q.size() == 1 && out_ready)) ? 1 : 0;
         chk(in_ready == exp_rdy[0], "in_ready", int'(in_ready), exp_rdy);
         chk(id_overflow == m_ovf, "id_overflow", int'(id_overflow), int'(m_ovf));
         if (q.size() > 0) begin
            e = q[0];
            if (!out_valid) begin
               chk(1'b0, "out_valid_bubble", 0, 1);
            end else begin
               checks++;
               if (int'(out_id) != e.id || int'(out_src_id) != e.src || int'(out_op) != e.op ||
                   int'(out_a) != e.a || int'(out_b) != e.b || int'(out_copy) != e.copy) begin
                  errors++;
                  $display("FAIL copy_fields: got id=%0d src=%0d op=%0d a=%0d b=%0d copy=%0d expected id=%0d src=%0d op=%0d a=%0d b=%0d copy=%0d",
                           out_id, out_src_id, out_op, out_a, out_b, out_copy,
                           e.id, e.src, e.op, e.a, e.b, e.copy);
               end
               if (out_ready) begin
                  void'(q.pop_front());
                  if (e.id == ID_MOD - 1) m_ovf = 1'b1;
               end
            end
         end else begin
            chk(!out_valid, "out_valid_spurious", int'(out_valid), 0);
         end
         if (in_valid && in_ready) begin
            for (int k = 0; k < int'(in_fanout); k++) begin
               e.id   = m_next;
               e.src  = int'(in_id);
               e.op   = int'(in_op);
               e.a    = int'(in_a);
               e.b    = int'(in_b);
               e.copy = k;
               q.push_back(e);
               m_next = (m_next + 1) % ID_MOD;
            end
         end
      end
   end

   // Offer one tuple; called just after a rising edge, returns just after the accepting edge
   task automatic send(input int id, input int op, input int a, input int b, input int fo);
      int n;
      in_valid  = 1'b1;
      in_id     = IDW'(id);
      in_op     = OPW'(op);
      in_a      = IDW'(a);
      in_b      = IDW'(b);
      in_fanout = FW'(fo);
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 500) begin
            chk(1'b0, "send_timeout", n, 500);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 || out_valid) begin
         @(negedge clk);
         n++;
         if (n > 2000) begin
            chk(1'b0, "drain_timeout", n, 2000);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
      chk(in_ready == 1'b1, "rst_in_ready", int'(in_ready), 1);
      chk(out_id == '0, "rst_out_id", int'(out_id), 0);
      chk(out_src_id == '0, "rst_out_src_id", int'(out_src_id), 0);
      chk(out_copy == '0, "rst_out_copy", int'(out_copy), 0);
      chk(out_a == '0 && out_b == '0 && out_op == '0, "rst_out_abop", int'({out_a, out_b, out_op}), 0);
      chk(id_overflow == 1'b0, "rst_id_overflow", int'(id_overflow), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int fo;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Fanout 3, then a dropped node, then single copy, then back-to-back pair
      send(5, OP_AND, 1, 2, 3);
      drain();
      send(7, OP_OR, 3, 4, 0);
      send(8, OP_XOR, 5, 6, 1);
      drain();
      do_reset();
      send(1, OP_AND, 2, 3, 2);
      send(2, OP_OR, 4, 5, 2);
      drain();

      // Backpressure: out_ready low while the first copy waits
      @(negedge clk);
      ready_mode = 2;
      @(posedge clk);
      #1;
      send(3, OP_NOT, 4, 5, 2);
      repeat (3) @(negedge clk);
      ready_mode = 0;
      @(posedge clk);
      #1;
      drain();

      // Allocator wrap: 17 copies from a clean start
      do_reset();
      send(11, OP_OR, 1, 2, 15);
      send(12, OP_AND, 3, 4, 2);
      drain();

      // Reset in the middle of a fanout-5 node
      do_reset();
      send(9, OP_XOR, 3, 4, 5);
      @(posedge clk);
      @(posedge clk);
      #1;
      do_reset();
      send(10, OP_AND, 6, 7, 1);
      drain();

      // Random tuples under random backpressure
      @(negedge clk);
      ready_mode = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 80; i++) begin
         fo = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 15)) : int'($urandom_range(0, 4));
         send(int'($urandom_range(0, ID_MOD - 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, ID_MOD - 1)), int'($urandom_range(0, ID_MOD - 1)), fo);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so the bench always ends
   initial begin
      #500000;
      $display("FAIL global_timeout: got %0t expected completion", $time);
      $fatal(1, "time limit reached");
   end

endmodule
